// File: rtl/axi_txn_sequencer.sv
// ---------------------------------------------------------------------------
// axi_txn_sequencer
//
// Kicks off up to three AXI master channels one after another. On an accepted
// start, the enabled channels (ch_mask) are run in ascending order. Each one
// gets an init strobe of INIT_PULSE_CYCLES cycles and is then waited on until
// it reports done or the TIMEOUT_CYCLES budget runs out. When the last enabled
// channel finishes, a single seq_done pulse is issued.
//
// Ports
//   ACLK, ARESET            clock; asynchronous active-high reset
//   start                   single-cycle request, accepted only in IDLE
//   abort                   drop the running sequence and return to IDLE
//   ch_mask[2:0]            channel enables, latched when start is accepted
//   Mxx_AXI_INIT_AXI_TXN    init strobe to channel 0/1/2 (registered)
//   Mxx_AXI_TXN_DONE        completion level from channel 0/1/2
//   Mxx_AXI_ERROR           error level from channel 0/1/2
//   busy                    high whenever the FSM is outside IDLE
//   seq_done                one-cycle pulse when a sequence ends normally
//   err_status[2:0]         sticky per-channel error capture
//   tmo_status[2:0]         sticky per-channel timeout flag
// ---------------------------------------------------------------------------
module axi_txn_sequencer #(
    parameter int unsigned INIT_PULSE_CYCLES = 2,
    parameter int unsigned TIMEOUT_CYCLES    = 4096
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] ch_mask,
    output logic       M00_AXI_INIT_AXI_TXN,
    output logic       M01_AXI_INIT_AXI_TXN,
    output logic       M02_AXI_INIT_AXI_TXN,
    input  logic       M00_AXI_TXN_DONE,
    input  logic       M01_AXI_TXN_DONE,
    input  logic       M02_AXI_TXN_DONE,
    input  logic       M00_AXI_ERROR,
    input  logic       M01_AXI_ERROR,
    input  logic       M02_AXI_ERROR,
    output logic       busy,
    output logic       seq_done,
    output logic [2:0] err_status,
    output logic [2:0] tmo_status
);

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned PCNT_W = 4;
    localparam int unsigned TCNT_W = 16;

    localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(INIT_PULSE_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TMO_LAST   = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TMO_MAX    = {TCNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PULSE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    state_t              state;
    logic [NUM_CH-1:0]   mask_q;
    logic [CH_W-1:0]     ch_q;
    logic [NUM_CH-1:0]   init_q;
    logic [PCNT_W-1:0]   pulse_cnt;
    logic [TCNT_W-1:0]   tmo_cnt;
    logic                busy_q;
    logic                seq_done_q;
    logic [NUM_CH-1:0]   err_q;
    logic [NUM_CH-1:0]   tmo_q;

    logic [NUM_CH-1:0]   done_vec_c;
    logic [NUM_CH-1:0]   err_vec_c;
    logic [NUM_CH-1:0]   sel_bit_c;
    logic                sel_done_c;
    logic [CH_W-1:0]     first_ch_c;
    logic                have_next_c;
    logic [CH_W-1:0]     next_ch_c;

    // Channel index to one-hot select; index 3 selects nothing.
    function automatic logic [NUM_CH-1:0] ch_bit(input logic [CH_W-1:0] ch);
        logic [NUM_CH-1:0] b;
        b = '0;
        case (ch)
            2'd0:    b = 3'b001;
            2'd1:    b = 3'b010;
            2'd2:    b = 3'b100;
            default: b = '0;
        endcase
        return b;
    endfunction

    // Gather per-channel inputs and select the active channel's done level.
    always_comb begin
        done_vec_c = {M02_AXI_TXN_DONE, M01_AXI_TXN_DONE, M00_AXI_TXN_DONE};
        err_vec_c  = {M02_AXI_ERROR, M01_AXI_ERROR, M00_AXI_ERROR};
        sel_bit_c  = ch_bit(ch_q);
        sel_done_c = |(done_vec_c & sel_bit_c);
    end

    // Lowest enabled channel at start, and next higher enabled channel.
    always_comb begin
        first_ch_c  = ch_mask[0] ? 2'd0 : (ch_mask[1] ? 2'd1 : 2'd2);
        have_next_c = 1'b0;
        next_ch_c   = ch_q;
        case (ch_q)
            2'd0: begin
                if (mask_q[1]) begin
                    have_next_c = 1'b1;
                    next_ch_c   = 2'd1;
                end else if (mask_q[2]) begin
                    have_next_c = 1'b1;
                    next_ch_c   = 2'd2;
                end
            end
            2'd1: begin
                if (mask_q[2]) begin
                    have_next_c = 1'b1;
                    next_ch_c   = 2'd2;
                end
            end
            default: begin
                have_next_c = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= ST_IDLE;
            mask_q     <= '0;
            ch_q       <= '0;
            init_q     <= '0;
            pulse_cnt  <= '0;
            tmo_cnt    <= '0;
            busy_q     <= 1'b0;
            seq_done_q <= 1'b0;
            err_q      <= '0;
            tmo_q      <= '0;
        end else begin
            seq_done_q <= 1'b0;
            // Abort wins over everything outside IDLE; status is kept.
            if (abort && (state != ST_IDLE)) begin
                state  <= ST_IDLE;
                init_q <= '0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            mask_q    <= ch_mask;
                            err_q     <= '0;
                            tmo_q     <= '0;
                            pulse_cnt <= '0;
                            tmo_cnt   <= '0;
                            busy_q    <= 1'b1;
                            if (ch_mask == '0) begin
                                state <= ST_FIN;
                            end else begin
                                ch_q   <= first_ch_c;
                                init_q <= ch_bit(first_ch_c);
                                state  <= ST_PULSE;
                            end
                        end
                    end

                    ST_PULSE: begin
                        if (pulse_cnt == PULSE_LAST) begin
                            init_q  <= '0;
                            tmo_cnt <= '0;
                            state   <= ST_WAIT;
                        end else begin
                            pulse_cnt <= pulse_cnt + PCNT_W'(1);
                        end
                    end

                    // Done is checked before expiry so a coincident done wins.
                    ST_WAIT: begin
                        if (sel_done_c) begin
                            err_q <= (err_q & ~sel_bit_c) | (err_vec_c & sel_bit_c);
                            state <= ST_NEXT;
                        end else if (tmo_cnt == TMO_LAST) begin
                            tmo_q <= tmo_q | sel_bit_c;
                            state <= ST_NEXT;
                        end else if (tmo_cnt != TMO_MAX) begin
                            tmo_cnt <= tmo_cnt + TCNT_W'(1);
                        end
                    end

                    ST_NEXT: begin
                        if (have_next_c) begin
                            ch_q      <= next_ch_c;
                            init_q    <= ch_bit(next_ch_c);
                            pulse_cnt <= '0;
                            state     <= ST_PULSE;
                        end else begin
                            state <= ST_FIN;
                        end
                    end

                    ST_FIN: begin
                        seq_done_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state      <= ST_IDLE;
                    end

                    default: begin
                        init_q <= '0;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign M00_AXI_INIT_AXI_TXN = init_q[0];
    assign M01_AXI_INIT_AXI_TXN = init_q[1];
    assign M02_AXI_INIT_AXI_TXN = init_q[2];
    assign busy                 = busy_q;
    assign seq_done             = seq_done_q;
    assign err_status           = err_q;
    assign tmo_status           = tmo_q;

endmodule

// File: tb/tb_axi_txn_sequencer.sv
// ---------------------------------------------------------------------------
// tb_axi_txn_sequencer
//
// Directed bench for axi_txn_sequencer (INIT_PULSE_CYCLES=2, TIMEOUT_CYCLES=16).
// A channel responder returns done about 10 cycles after each init falls; a
// monitor records init pulse counts, order and seq_done pulses per scenario.
// ---------------------------------------------------------------------------
module tb_axi_txn_sequencer;

    logic       clk;
    logic       ARESET;
    logic       start;
    logic       abort;
    logic [2:0] ch_mask;
    logic       m00_init, m01_init, m02_init;
    logic       busy, seq_done;
    logic [2:0] err_status, tmo_status;

    logic [2:0] resp_en, resp_err, resp_done;
    logic [2:0] man_done, man_err;
    logic [2:0] done_in, err_in;
    logic [2:0] inits;
    logic [10:0] all_outs;

    assign done_in  = resp_done | man_done;
    assign err_in   = (resp_done & resp_err) | man_err;
    assign inits    = {m02_init, m01_init, m00_init};
    assign all_outs = {inits, busy, seq_done, err_status, tmo_status};

    axi_txn_sequencer #(
        .INIT_PULSE_CYCLES (2),
        .TIMEOUT_CYCLES    (16)
    ) dut (
        .ACLK                 (clk),
        .ARESET               (ARESET),
        .start                (start),
        .abort                (abort),
        .ch_mask              (ch_mask),
        .M00_AXI_INIT_AXI_TXN (m00_init),
        .M01_AXI_INIT_AXI_TXN (m01_init),
        .M02_AXI_INIT_AXI_TXN (m02_init),
        .M00_AXI_TXN_DONE     (done_in[0]),
        .M01_AXI_TXN_DONE     (done_in[1]),
        .M02_AXI_TXN_DONE     (done_in[2]),
        .M00_AXI_ERROR        (err_in[0]),
        .M01_AXI_ERROR        (err_in[1]),
        .M02_AXI_ERROR        (err_in[2]),
        .busy                 (busy),
        .seq_done             (seq_done),
        .err_status           (err_status),
        .tmo_status           (tmo_status)
    );

    int unsigned errors;
    int unsigned checks;

    // Monitor state
    int unsigned rises [3];
    int unsigned hi_cyc[3];
    int unsigned order;
    int unsigned seq_done_cnt;
    int unsigned multi_init;
    logic [2:0]  mon_prev;

    // Responder state
    int          cd[3];
    logic [2:0]  resp_prev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        for (int n = 0; n < 3; n++) begin
            rises[n]  = 0;
            hi_cyc[n] = 0;
        end
        order        = 0;
        seq_done_cnt = 0;
        multi_init   = 0;
    endtask

    // Leaves the bench in the cycle right after the accepting edge.
    task automatic do_start(input logic [2:0] m);
        start   = 1'b1;
        ch_mask = m;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("wait_idle", 32'(busy), 32'd0);
        tick();
    endtask

    // Monitor: init pulse lengths, start order, overlap, seq_done pulses.
    initial begin
        mon_prev = '0;
        forever begin
            @(negedge clk);
            if ($countones(inits) > 1) multi_init++;
            for (int n = 0; n < 3; n++) begin
                if (inits[n] && !mon_prev[n]) begin
                    rises[n]++;
                    order = order * 4 + 32'(n) + 1;
                end
                if (inits[n]) hi_cyc[n]++;
            end
            if (seq_done) seq_done_cnt++;
            mon_prev = inits;
        end
    end

    // Responder: one-cycle done about 10 cycles after an enabled init falls.
    initial begin
        resp_prev = '0;
        resp_done = '0;
        for (int n = 0; n < 3; n++) cd[n] = 0;
        forever begin
            @(negedge clk);
            for (int n = 0; n < 3; n++) begin
                resp_done[n] = 1'b0;
                if (ARESET) begin
                    cd[n] = 0;
                end else if (resp_prev[n] && !inits[n] && resp_en[n]) begin
                    cd[n] = 10;
                end else if (cd[n] > 0) begin
                    cd[n]--;
                    if (cd[n] == 0) resp_done[n] = 1'b1;
                end
            end
            resp_prev = inits;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        errors   = 0;
        checks   = 0;
        ARESET   = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        ch_mask  = '0;
        resp_en  = '0;
        resp_err = '0;
        man_done = '0;
        man_err  = '0;
        clear_mon();

        repeat (3) tick();
        check("reset_outs", 32'(all_outs), 32'd0);

        // Scenario 1: all channels, no errors; start on first edge out of reset.
        ARESET   = 1'b0;
        resp_en  = 3'b111;
        resp_err = 3'b000;
        clear_mon();
        do_start(3'b111);
        check("s1_first_init", 32'(inits), 32'h1);
        check("s1_busy", 32'(busy), 32'd1);
        wait_idle(300);
        check("s1_order", order, 32'd27);
        check("s1_len0", hi_cyc[0], 32'd2);
        check("s1_len1", hi_cyc[1], 32'd2);
        check("s1_len2", hi_cyc[2], 32'd2);
        check("s1_seq_done", seq_done_cnt, 32'd1);
        check("s1_err", 32'(err_status), 32'h0);
        check("s1_tmo", 32'(tmo_status), 32'h0);
        check("s1_onehot", multi_init, 32'd0);

        // Scenario 2: mask 101, ch2 errors; ch1 done/error held high and a
        // mid-sequence start must both be ignored.
        resp_err = 3'b100;
        man_done = 3'b010;
        man_err  = 3'b010;
        clear_mon();
        do_start(3'b101);
        repeat (5) tick();
        start   = 1'b1;
        ch_mask = 3'b010;
        tick();
        start   = 1'b0;
        wait_idle(300);
        man_done = '0;
        man_err  = '0;
        check("s2_no_m01", rises[1], 32'd0);
        check("s2_order", order, 32'd7);
        check("s2_err", 32'(err_status), 32'h4);
        check("s2_tmo", 32'(tmo_status), 32'h0);
        check("s2_seq_done", seq_done_cnt, 32'd1);

        // Scenario 4: empty mask.
        clear_mon();
        do_start(3'b000);
        check("s4_busy_c1", 32'(busy), 32'd1);
        check("s4_done_c1", 32'(seq_done), 32'd0);
        tick();
        check("s4_busy_c2", 32'(busy), 32'd0);
        check("s4_done_c2", 32'(seq_done), 32'd1);
        tick();
        check("s4_done_c3", 32'(seq_done), 32'd0);
        tick();
        check("s4_seq_done", seq_done_cnt, 32'd1);
        check("s4_no_init", rises[0] + rises[1] + rises[2], 32'd0);

        // Scenario 3: ch1 never completes; WAIT covers cycles 3..18.
        resp_en = 3'b000;
        clear_mon();
        do_start(3'b010);
        repeat (17) tick();
        check("s3_tmo_c18", 32'(tmo_status), 32'h0);
        check("s3_busy_c18", 32'(busy), 32'd1);
        tick();
        check("s3_tmo_c19", 32'(tmo_status), 32'h2);
        check("s3_err_c19", 32'(err_status), 32'h0);
        tick();
        check("s3_done_c20", 32'(seq_done), 32'd0);
        tick();
        check("s3_done_c21", 32'(seq_done), 32'd1);
        tick();

        // Done with error arriving on the last WAIT cycle beats the timeout.
        do_start(3'b010);
        repeat (17) tick();
        man_done = 3'b010;
        man_err  = 3'b010;
        tick();
        man_done = '0;
        man_err  = '0;
        check("s3b_err", 32'(err_status), 32'h2);
        check("s3b_tmo", 32'(tmo_status), 32'h0);
        wait_idle(20);

        // Scenario 5: abort during ch1 WAIT; ch0 error must be retained.
        resp_en  = 3'b111;
        resp_err = 3'b001;
        clear_mon();
        do_start(3'b111);
        n = 0;
        while (m01_init !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("s5_m01_rise", 32'(m01_init), 32'd1);
        n = 0;
        while (m01_init !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check("s5_m01_fall", 32'(m01_init), 32'd0);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_inits", 32'(inits), 32'h0);
        repeat (30) tick();
        check("s5_no_done", seq_done_cnt, 32'd0);
        check("s5_no_m02", rises[2], 32'd0);
        check("s5_err_kept", 32'(err_status), 32'h1);

        // Start together with abort in IDLE is ignored.
        start   = 1'b1;
        abort   = 1'b1;
        ch_mask = 3'b111;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("s5_abort_start_busy", 32'(busy), 32'd0);
        check("s5_abort_start_err", 32'(err_status), 32'h1);

        // Scenario 6: reset during ch0 PULSE, then a fresh sequence.
        resp_err = 3'b000;
        do_start(3'b001);
        check("s6_pulse", 32'(inits), 32'h1);
        #2;
        ARESET = 1'b1;
        #1;
        check("s6_async_rst", 32'(all_outs), 32'd0);
        tick();
        tick();
        check("s6_hold_rst", 32'(all_outs), 32'd0);
        ARESET = 1'b0;
        clear_mon();
        repeat (15) tick();
        check("s6_no_done", seq_done_cnt, 32'd0);
        check("s6_idle", 32'(busy), 32'd0);
        do_start(3'b001);
        wait_idle(100);
        check("s6_seq_done", seq_done_cnt, 32'd1);
        check("s6_rise0", rises[0], 32'd1);
        check("s6_len0", hi_cyc[0], 32'd2);
        check("s6_err", 32'(err_status), 32'h0);
        check("s6_tmo", 32'(tmo_status), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
